// File: rtl/way_arbiter_if.sv
// Requester/downstream bundle for way_arbiter.
//   req       : level request, one bit per requester
//   req_len   : packed burst lengths, requester i at [i*LEN_WIDTH +: LEN_WIDTH]
//   bus_ready : downstream accepts one beat this cycle
//   gnt       : one-hot registered grant
//   gnt_id    : binary index of the granted requester (valid while busy)
//   busy      : burst in progress
//   done      : one-cycle pulse after the last beat is accepted
// The slave modport is the arbiter's view; master is the requester/downstream side.
interface way_arbiter_if #(
  parameter int unsigned SLV_NUM   = 3,
  parameter int unsigned LEN_WIDTH = 4,
  parameter int unsigned ID_WIDTH  = 2
);
  logic [SLV_NUM-1:0]           req;
  logic [SLV_NUM*LEN_WIDTH-1:0] req_len;
  logic                         bus_ready;
  logic [SLV_NUM-1:0]           gnt;
  logic [ID_WIDTH-1:0]          gnt_id;
  logic                         busy;
  logic                         done;

  modport master (
    output req, req_len, bus_ready,
    input  gnt, gnt_id, busy, done
  );

  modport slave (
    input  req, req_len, bus_ready,
    output gnt, gnt_id, busy, done
  );
endinterface

// File: rtl/way_arbiter.sv
// Burst arbiter for a shared downstream port.
// Ports:
//   pclk   : clock, rising edge
//   rst_b  : asynchronous active-low reset
//   way_en : per-requester enable mask (config register)
//   qos_en : 1 = fixed priority (index 0 highest), 0 = round-robin
//   bus    : way_arbiter_if slave (req/req_len/bus_ready in, gnt/gnt_id/busy/done out)
// A winner holds the port for len+1 beats, each beat counted on bus_ready.
module way_arbiter #(
  parameter int unsigned SLV_NUM   = 3,
  parameter int unsigned LEN_WIDTH = 4,
  parameter int unsigned ID_WIDTH  = 2
) (
  input  logic               pclk,
  input  logic               rst_b,
  input  logic [SLV_NUM-1:0] way_en,
  input  logic               qos_en,
  way_arbiter_if.slave       bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e               state;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [LEN_WIDTH-1:0] beat_cnt;

  logic [SLV_NUM-1:0]   eligible;
  logic                 lo_found;
  logic                 hi_found;
  logic [ID_WIDTH-1:0]  lo_id;
  logic [ID_WIDTH-1:0]  hi_id;
  logic [ID_WIDTH-1:0]  win_id;
  logic [ID_WIDTH-1:0]  rr_next;
  logic [SLV_NUM-1:0]   win_oh;
  logic [LEN_WIDTH-1:0] win_len;

  assign eligible = bus.req & way_en;

  // Round-robin from rr_ptr is "lowest eligible at or above rr_ptr, else lowest
  // eligible overall"; fixed priority is simply the lowest eligible.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_id    = '0;
    hi_id    = '0;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (eligible[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = ID_WIDTH'(i);
      end
      if (eligible[i] && !hi_found && (i >= 32'(rr_ptr))) begin
        hi_found = 1'b1;
        hi_id    = ID_WIDTH'(i);
      end
    end
    win_id = (!qos_en && hi_found) ? hi_id : lo_id;
  end

  always_comb begin
    win_oh  = '0;
    win_len = '0;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (ID_WIDTH'(i) == win_id) begin
        win_oh[i] = 1'b1;
        win_len   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
    rr_next = (32'(win_id) == SLV_NUM - 1) ? '0 : win_id + ID_WIDTH'(1);
  end

  always_ff @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= StIdle;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      bus.gnt    <= '0;
      bus.gnt_id <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (lo_found) begin
            state      <= StBusy;
            beat_cnt   <= win_len;
            bus.gnt    <= win_oh;
            bus.gnt_id <= win_id;
            bus.busy   <= 1'b1;
            // Pointer advances on every grant, fixed-priority ones included.
            rr_ptr     <= rr_next;
          end else begin
            bus.gnt <= '0;
          end
        end
        StBusy: begin
          if (bus.bus_ready) begin
            if (beat_cnt != '0) begin
              beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            end else begin
              state    <= StIdle;
              bus.gnt  <= '0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_way_arbiter.sv
// Self-checking bench for way_arbiter: a burst-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_way_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned LW = 4;
  localparam int unsigned IW = 2;

  logic         pclk = 1'b0;
  logic         rst_b = 1'b0;
  logic [N-1:0] way_en;
  logic         qos_en;

  way_arbiter_if #(.SLV_NUM(N), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  way_arbiter #(.SLV_NUM(N), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .pclk   (pclk),
    .rst_b  (rst_b),
    .way_en (way_en),
    .qos_en (qos_en),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: burst in flight with a count of beats still owed.
  logic m_busy;
  logic m_done;
  int   m_id;
  int   m_left;
  int   m_rr;
  int   m_w;
  int   m_c;
  int   grants[$];

  always @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_id   = 0;
      m_left = 0;
      m_rr   = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.bus_ready) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else begin
        m_w = -1;
        for (int k = 0; k < N; k++) begin
          m_c = qos_en ? k : (m_rr + k) % N;
          if (m_w < 0 && bus.req[m_c] && way_en[m_c]) m_w = m_c;
        end
        if (m_w >= 0) begin
          m_busy = 1'b1;
          m_id   = m_w;
          m_left = int'(bus.req_len[m_w*LW +: LW]) + 1;
          m_rr   = (m_w + 1) % N;
          grants.push_back(m_w);
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge pclk) begin
    if (rst_b) begin
      check("gnt", int'(bus.gnt), m_busy ? (1 << m_id) : 0);
      check("busy", int'(bus.busy), int'(m_busy));
      check("done", int'(bus.done), int'(m_done));
      check("gnt_multi", int'($countones(bus.gnt) > 1), 0);
      if (m_busy) check("gnt_id", int'(bus.gnt_id), m_id);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 60) begin
      @(negedge pclk);
      n++;
    end
    check("idle_timeout", int'(bus.busy || bus.done), 0);
  endtask

  int          nb;
  int          held;
  int          n;
  logic [4:0]  pat;
  int          exp_rr[5];

  initial begin
    way_en        = '0;
    qos_en        = 1'b0;
    bus.req       = '0;
    bus.req_len   = '0;
    bus.bus_ready = 1'b0;
    exp_rr        = '{0, 1, 2, 0, 1};

    // Reset values
    repeat (2) @(negedge pclk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_gnt_id", int'(bus.gnt_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    rst_b = 1'b1;
    @(negedge pclk);

    // Single request from requester 1, len 3
    way_en        = 3'b111;
    bus.req       = 3'b010;
    bus.req_len   = {4'd0, 4'd3, 4'd0};
    bus.bus_ready = 1'b1;
    @(negedge pclk);
    check("single_gnt", int'(bus.gnt), 2);
    check("single_id", int'(bus.gnt_id), 1);
    bus.req = '0;
    nb = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.busy) nb++;
      @(negedge pclk);
    end
    check("single_busy_cycles", nb, 4);
    check("single_done", int'(bus.done), 1);
    @(negedge pclk);
    check("single_done_pulse", int'(bus.done), 0);
    wait_idle();

    // Fixed priority: requester 0 always wins
    grants.delete();
    qos_en      = 1'b1;
    bus.req_len = '0;
    bus.req     = 3'b111;
    repeat (12) @(negedge pclk);
    bus.req = '0;
    wait_idle();
    check("fixed_grant_count", int'(grants.size() >= 5), 1);
    foreach (grants[i]) check("fixed_winner", grants[i], 0);

    // Round-robin wrap from a freshly reset pointer
    rst_b = 1'b0;
    @(negedge pclk);
    rst_b = 1'b1;
    grants.delete();
    qos_en  = 1'b0;
    bus.req = 3'b111;
    n = 0;
    while (grants.size() < 5 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    bus.req = '0;
    check("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_order", grants[i], exp_rr[i]);
    wait_idle();

    // Masking
    way_en  = 3'b100;
    bus.req = 3'b011;
    repeat (3) @(negedge pclk);
    check("mask_busy", int'(bus.busy), 0);
    check("mask_gnt", int'(bus.gnt), 0);
    way_en = 3'b001;
    @(negedge pclk);
    check("unmask_gnt", int'(bus.gnt), 1);
    bus.req = '0;
    wait_idle();

    // Backpressure with way_en/req dropped mid-burst
    way_en        = 3'b111;
    bus.req       = 3'b100;
    bus.req_len   = {4'd2, 4'd0, 4'd0};
    bus.bus_ready = 1'b1;
    @(negedge pclk);
    pat  = 5'b11001;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.gnt == 3'b100) held++;
      bus.bus_ready = pat[i];
      if (i == 0) begin
        way_en[2]  = 1'b0;
        bus.req[2] = 1'b0;
      end
      @(negedge pclk);
    end
    check("bp_gnt_held", held, 5);
    check("bp_done", int'(bus.done), 1);
    bus.bus_ready = 1'b1;
    way_en        = 3'b111;
    wait_idle();

    // Reset during the second beat
    bus.req     = 3'b001;
    bus.req_len = {4'd0, 4'd0, 4'd3};
    @(negedge pclk);
    check("rstmid_gnt_before", int'(bus.gnt), 1);
    bus.req = '0;
    @(negedge pclk);
    #2 rst_b = 1'b0;
    #1;
    check("rstmid_gnt", int'(bus.gnt), 0);
    check("rstmid_busy", int'(bus.busy), 0);
    check("rstmid_done", int'(bus.done), 0);
    @(negedge pclk);
    rst_b       = 1'b1;
    bus.req_len = '0;
    bus.req     = 3'b111;
    qos_en      = 1'b0;
    @(negedge pclk);
    check("rstmid_rr_gnt_id", int'(bus.gnt_id), 0);
    check("rstmid_rr_gnt", int'(bus.gnt), 1);
    bus.req = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
